// File: rtl/cruise_speed_regulator.sv
// cruise_speed_regulator
//   Consumer of the speed comparator's G/Eq/L result. It debounces the
//   comparator code, runs the IDLE/HOLD/ACCEL/DECEL cruise FSM and ramps a
//   saturating throttle level. accel/decel/locked/throttle are registered.
//
//   Optional feature macro: INVALID_CODE_CHECK_EN
//     defined   : a non-one-hot {G,Eq,L} code in HOLD/ACCEL/DECEL raises a
//                 sticky fault, forces IDLE with throttle 0, and only reset
//                 clears it.
//     undefined : fault is held at 0 and illegal codes are treated as Eq.
//
//   dbg_state exposes the FSM state: 0=IDLE 1=HOLD 2=ACCEL 3=DECEL.
//
//   Handshake: there is no valid/ready pairing here. The comparator code is
//   sampled on every rising clock edge, and every output is updated on every
//   edge.
module cruise_speed_regulator #(
   parameter int SETTLE      = 4,
   parameter int STEP_PERIOD = 8,
   parameter int LEVEL_W     = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               brake,
   input  logic               G,
   input  logic               Eq,
   input  logic               L,
   output logic [LEVEL_W-1:0] throttle,
   output logic               accel,
   output logic               decel,
   output logic               locked,
   output logic               fault,
   output logic [1:0]         dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HOLD  = 2'd1,
      S_ACCEL = 2'd2,
      S_DECEL = 2'd3
   } state_t;

   // Comparator code after decode; illegal codes fold onto Eq.
   localparam logic [1:0] C_L  = 2'd0;
   localparam logic [1:0] C_EQ = 2'd1;
   localparam logic [1:0] C_G  = 2'd2;

   localparam int SW = $clog2(SETTLE + 1);
   localparam int TW = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;

   localparam logic [SW-1:0]      SETTLE_V = SW'(SETTLE);
   localparam logic [TW-1:0]      STEP_TOP = TW'(STEP_PERIOD - 1);
   localparam logic [LEVEL_W-1:0] LVL_MAX  = '1;

   state_t             state;
   logic [SW-1:0]      settle_cnt;
   logic [TW-1:0]      step_cnt;
   logic [1:0]         last_code;

   logic               code_valid;
   logic               bad_code;
   logic [1:0]         cur_code;
   logic [SW-1:0]      settle_next;
   logic               step_wrap;

   // Decode the comparator triple and work out the next debounce count.
   always_comb begin
      code_valid = ({G, Eq, L} == 3'b100) || ({G, Eq, L} == 3'b010) ||
                   ({G, Eq, L} == 3'b001);
      cur_code   = C_EQ;
      if (code_valid && L) cur_code = C_L;
      if (code_valid && G) cur_code = C_G;
`ifdef INVALID_CODE_CHECK_EN
      bad_code   = !code_valid;
`else
      bad_code   = 1'b0;
`endif
      // A fresh state (count 0) or a different code restarts the run at 1;
      // the count saturates at SETTLE so a long Eq run keeps locked asserted.
      if ((settle_cnt != '0) && (cur_code == last_code)) begin
         settle_next = (settle_cnt == SETTLE_V) ? SETTLE_V : settle_cnt + 1'b1;
      end else begin
         settle_next = SW'(1);
      end
      step_wrap = (step_cnt == STEP_TOP);
   end

   // Cruise FSM with registered outputs; reset > brake/disable > fault > FSM.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         throttle   <= '0;
         accel      <= 1'b0;
         decel      <= 1'b0;
         locked     <= 1'b0;
         fault      <= 1'b0;
         settle_cnt <= '0;
         step_cnt   <= '0;
         last_code  <= C_EQ;
      end else if (brake || !enable || fault) begin
         // A latched fault parks the block in IDLE exactly like a disengage.
         state      <= S_IDLE;
         throttle   <= '0;
         accel      <= 1'b0;
         decel      <= 1'b0;
         locked     <= 1'b0;
         settle_cnt <= '0;
         step_cnt   <= '0;
      end else if (bad_code && (state != S_IDLE)) begin
         state      <= S_IDLE;
         fault      <= 1'b1;
         throttle   <= '0;
         accel      <= 1'b0;
         decel      <= 1'b0;
         locked     <= 1'b0;
         settle_cnt <= '0;
         step_cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               state      <= S_HOLD;
               throttle   <= '0;
               settle_cnt <= '0;
               step_cnt   <= '0;
            end
            S_HOLD: begin
               last_code <= cur_code;
               if ((settle_next == SETTLE_V) && (cur_code == C_L)) begin
                  state      <= S_ACCEL;
                  accel      <= 1'b1;
                  locked     <= 1'b0;
                  settle_cnt <= '0;
                  step_cnt   <= '0;
               end else if ((settle_next == SETTLE_V) && (cur_code == C_G)) begin
                  state      <= S_DECEL;
                  decel      <= 1'b1;
                  locked     <= 1'b0;
                  settle_cnt <= '0;
                  step_cnt   <= '0;
               end else begin
                  settle_cnt <= settle_next;
                  locked     <= (cur_code == C_EQ) && (settle_next == SETTLE_V);
               end
            end
            S_ACCEL: begin
               if (cur_code != C_L) begin
                  state      <= S_HOLD;
                  accel      <= 1'b0;
                  settle_cnt <= '0;
                  step_cnt   <= '0;
               end else if (step_wrap) begin
                  step_cnt <= '0;
                  if (throttle != LVL_MAX) throttle <= throttle + 1'b1;
               end else begin
                  step_cnt <= step_cnt + 1'b1;
               end
            end
            S_DECEL: begin
               if (cur_code != C_G) begin
                  state      <= S_HOLD;
                  decel      <= 1'b0;
                  settle_cnt <= '0;
                  step_cnt   <= '0;
               end else if (step_wrap) begin
                  step_cnt <= '0;
                  if (throttle != '0) throttle <= throttle - 1'b1;
               end else begin
                  step_cnt <= step_cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign dbg_state = state;

endmodule
